// File: rtl/clock_pkg.sv
// Shared types and constants for the 24h clock time-of-day datapath.
// The helper converts a small binary constant into its two-digit BCD form.
package clock_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2
    } mode_e;

    typedef logic [7:0] bcd2_t;

    localparam int DEFAULT_HOURS_MOD   = 24;
    localparam int DEFAULT_MINUTES_MOD = 60;

    function automatic bcd2_t to_bcd2(input int unsigned v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

endpackage

// File: rtl/time_of_day_counter_if.sv
// Bus between the tick/button sources and the time-of-day counter.
// master drives ticks and buttons; slave is the counter presenting the display values.
interface time_of_day_counter_if;

    logic                  tick_s;
    logic                  tick_hs;
    logic                  btn_mode;
    logic                  btn_inc;
    clock_pkg::bcd2_t      h_bcd;
    clock_pkg::bcd2_t      m_bcd;
    clock_pkg::bcd2_t      s_bcd;
    logic [5:0]            digit_en;
    clock_pkg::mode_e      mode;

    modport master (
        output tick_s, tick_hs, btn_mode, btn_inc,
        input  h_bcd, m_bcd, s_bcd, digit_en, mode
    );

    modport slave (
        input  tick_s, tick_hs, btn_mode, btn_inc,
        output h_bcd, m_bcd, s_bcd, digit_en, mode
    );

endinterface

// File: rtl/bcd2_counter.sv
// Two-digit BCD counter wrapping at MOD-1 -> 00.
// wrap is combinational so the next stage can advance in the same cycle.
module bcd2_counter
    import clock_pkg::*;
#(
    parameter int MOD = 60
) (
    input  logic  clk_in,
    input  logic  rst,
    input  logic  inc,
    input  logic  clr,
    output bcd2_t value,
    output logic  wrap
);

    localparam bcd2_t LAST = to_bcd2(MOD - 1);

    assign wrap = inc && (value == LAST);

    always_ff @(posedge clk_in) begin
        if (rst || clr) begin
            value <= 8'h00;
        end else if (inc) begin
            if (wrap) begin
                value <= 8'h00;
            end else if (value[3:0] == 4'd9) begin
                value <= {value[7:4] + 4'd1, 4'd0};
            end else begin
                value <= {value[7:4], value[3:0] + 4'd1};
            end
        end
    end

endmodule

// File: rtl/time_of_day_counter.sv
// Hours:minutes:seconds keeper with a button-driven set mode and blinking field enables.
// Carries ripple combinationally through the three counters, so a full rollover lands in one cycle.
module time_of_day_counter
    import clock_pkg::*;
#(
    parameter int HOURS_MOD   = DEFAULT_HOURS_MOD,
    parameter int MINUTES_MOD = DEFAULT_MINUTES_MOD
) (
    input  logic                  clk_in,
    input  logic                  rst,
    time_of_day_counter_if.slave  bus
);

    mode_e      mode_q;
    mode_e      next_mode;
    logic       phase_q;
    logic       next_phase;
    logic [5:0] digit_en_q;
    logic [5:0] next_digit_en;
    logic       mode_prev_q;
    logic       inc_prev_q;

    logic       mode_press;
    logic       inc_press;
    logic       run;
    logic       sec_inc, sec_clr, sec_wrap;
    logic       min_inc, min_wrap;
    logic       hr_inc, hr_wrap_unused;
    bcd2_t      sec_val, min_val, hr_val;

    // A mode press wins over a simultaneous inc press.
    assign mode_press = bus.btn_mode & ~mode_prev_q;
    assign inc_press  = bus.btn_inc & ~inc_prev_q & ~mode_press;
    assign run        = (mode_q == RUN);

    assign sec_inc = run & bus.tick_s;
    assign sec_clr = (run & mode_press) | (mode_q == SET_HOUR);
    assign min_inc = run ? sec_wrap : ((mode_q == SET_MIN) & inc_press);
    assign hr_inc  = run ? min_wrap : ((mode_q == SET_HOUR) & inc_press);

    always_comb begin
        next_mode = RUN;
        case (mode_q)
            RUN:      next_mode = mode_press ? SET_HOUR : RUN;
            SET_HOUR: next_mode = mode_press ? SET_MIN  : SET_HOUR;
            SET_MIN:  next_mode = mode_press ? RUN      : SET_MIN;
            default:  next_mode = RUN;
        endcase
    end

    // Phase restarts on any mode change so the newly selected field is lit at once.
    always_comb begin
        next_phase = phase_q;
        if (next_mode != mode_q) begin
            next_phase = 1'b0;
        end else if (bus.tick_hs) begin
            next_phase = ~phase_q;
        end
        next_digit_en = 6'h3F;
        if (next_mode == SET_HOUR) begin
            next_digit_en[5:4] = {2{~next_phase}};
        end else if (next_mode == SET_MIN) begin
            next_digit_en[3:2] = {2{~next_phase}};
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            mode_q     <= RUN;
            phase_q    <= 1'b0;
            digit_en_q <= 6'h3F;
        end else begin
            mode_q     <= next_mode;
            phase_q    <= next_phase;
            digit_en_q <= next_digit_en;
        end
    end

    // Edge-detect history follows the button levels even during reset, so a
    // button still held when reset is released does not register as a press.
    always_ff @(posedge clk_in) begin
        mode_prev_q <= bus.btn_mode;
        inc_prev_q  <= bus.btn_inc;
    end

    bcd2_counter #(.MOD(MINUTES_MOD)) u_sec (
        .clk_in (clk_in),
        .rst    (rst),
        .inc    (sec_inc),
        .clr    (sec_clr),
        .value  (sec_val),
        .wrap   (sec_wrap)
    );

    bcd2_counter #(.MOD(MINUTES_MOD)) u_min (
        .clk_in (clk_in),
        .rst    (rst),
        .inc    (min_inc),
        .clr    (1'b0),
        .value  (min_val),
        .wrap   (min_wrap)
    );

    bcd2_counter #(.MOD(HOURS_MOD)) u_hr (
        .clk_in (clk_in),
        .rst    (rst),
        .inc    (hr_inc),
        .clr    (1'b0),
        .value  (hr_val),
        .wrap   (hr_wrap_unused)
    );

    assign bus.h_bcd    = hr_val;
    assign bus.m_bcd    = min_val;
    assign bus.s_bcd    = sec_val;
    assign bus.digit_en = digit_en_q;
    assign bus.mode     = mode_q;

endmodule

// File: tb/tb_time_of_day_counter.sv
// Directed bench for time_of_day_counter: drivers push expected snapshots,
// a negedge monitor pops and compares them against the live outputs.
module tb_time_of_day_counter;
    import clock_pkg::*;

    localparam int W = 32;

    logic clk_in = 1'b0;
    logic rst    = 1'b1;

    always #5 clk_in = ~clk_in;

    time_of_day_counter_if bus ();

    time_of_day_counter #(
        .HOURS_MOD   (24),
        .MINUTES_MOD (60)
    ) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .bus    (bus.slave)
    );

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           checks = 0;
    int           errors = 0;

    logic [W-1:0] mon_exp;
    logic [W-1:0] mon_act;
    string        mon_name;

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic push_exp(input string nm, input logic [7:0] h, input logic [7:0] m,
                            input logic [7:0] s, input logic [5:0] en, input logic [1:0] md);
        exp_q.push_back({h, m, s, en, md});
        name_q.push_back(nm);
    endtask

    task automatic press_mode();
        bus.btn_mode = 1'b1;
        step(1);
        bus.btn_mode = 1'b0;
        step(1);
    endtask

    task automatic press_inc(input int n);
        repeat (n) begin
            bus.btn_inc = 1'b1;
            step(1);
            bus.btn_inc = 1'b0;
            step(1);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            bus.tick_s  = 1'b1;
            bus.tick_hs = i[0];
            step(1);
            bus.tick_s  = 1'b0;
            bus.tick_hs = 1'b0;
            step(9);
        end
    endtask

    task automatic pulse_hs();
        bus.tick_hs = 1'b1;
        step(1);
        bus.tick_hs = 1'b0;
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk_in) begin
        while (exp_q.size() > 0) begin
            mon_exp  = exp_q.pop_front();
            mon_name = name_q.pop_front();
            mon_act  = {bus.h_bcd, bus.m_bcd, bus.s_bcd, bus.digit_en, bus.mode};
            checks++;
            if (mon_act !== mon_exp) begin
                errors++;
                $display("FAIL %s: got h=%h m=%h s=%h en=%b mode=%0d, expected h=%h m=%h s=%h en=%b mode=%0d",
                         mon_name, mon_act[31:24], mon_act[23:16], mon_act[15:8], mon_act[7:2], mon_act[1:0],
                         mon_exp[31:24], mon_exp[23:16], mon_exp[15:8], mon_exp[7:2], mon_exp[1:0]);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bus.tick_s   = 1'b0;
        bus.tick_hs  = 1'b0;
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;

        rst = 1'b1;
        step(3);
        push_exp("in_reset", 8'h00, 8'h00, 8'h00, 6'h3F, 2'd0);
        rst = 1'b0;
        step(1);
        push_exp("after_reset", 8'h00, 8'h00, 8'h00, 6'h3F, 2'd0);

        // 61 seconds in RUN with half-second ticks mixed in
        ticks(59);
        push_exp("run_59s", 8'h00, 8'h00, 8'h59, 6'h3F, 2'd0);
        ticks(1);
        push_exp("run_sec_carry", 8'h00, 8'h01, 8'h00, 6'h3F, 2'd0);
        ticks(1);
        push_exp("run_61s", 8'h00, 8'h01, 8'h01, 6'h3F, 2'd0);

        // set hours
        press_mode();
        push_exp("enter_set_hour", 8'h00, 8'h01, 8'h00, 6'h3F, 2'd1);
        bus.btn_inc = 1'b1;
        step(100);
        push_exp("held_inc_once", 8'h01, 8'h01, 8'h00, 6'h3F, 2'd1);
        bus.btn_inc = 1'b0;
        step(1);
        press_inc(22);
        push_exp("hour_23", 8'h23, 8'h01, 8'h00, 6'h3F, 2'd1);
        press_inc(1);
        push_exp("hour_wrap", 8'h00, 8'h01, 8'h00, 6'h3F, 2'd1);
        press_inc(25);
        push_exp("hour_25_presses", 8'h01, 8'h01, 8'h00, 6'h3F, 2'd1);
        press_inc(22);
        ticks(1);
        push_exp("tick_in_set_hour", 8'h23, 8'h01, 8'h00, 6'h3F, 2'd1);

        // set minutes
        press_mode();
        push_exp("enter_set_min", 8'h23, 8'h01, 8'h00, 6'h3F, 2'd2);
        press_inc(58);
        push_exp("min_59", 8'h23, 8'h59, 8'h00, 6'h3F, 2'd2);
        press_inc(1);
        push_exp("min_wrap_no_carry", 8'h23, 8'h00, 8'h00, 6'h3F, 2'd2);
        press_inc(59);
        pulse_hs();
        push_exp("blink_min_1", 8'h23, 8'h59, 8'h00, 6'h33, 2'd2);
        pulse_hs();
        push_exp("blink_min_2", 8'h23, 8'h59, 8'h00, 6'h3F, 2'd2);
        pulse_hs();
        push_exp("blink_min_3", 8'h23, 8'h59, 8'h00, 6'h33, 2'd2);
        pulse_hs();
        push_exp("blink_min_4", 8'h23, 8'h59, 8'h00, 6'h3F, 2'd2);
        step(1);
        pulse_hs();
        step(1);

        // back to RUN with phase 1, then full rollover
        press_mode();
        push_exp("back_to_run", 8'h23, 8'h59, 8'h00, 6'h3F, 2'd0);
        ticks(59);
        push_exp("run_235959", 8'h23, 8'h59, 8'h59, 6'h3F, 2'd0);
        ticks(1);
        push_exp("run_rollover", 8'h00, 8'h00, 8'h00, 6'h3F, 2'd0);

        // simultaneous mode + inc + tick in SET_HOUR
        press_mode();
        press_inc(1);
        push_exp("set_hour_01", 8'h01, 8'h00, 8'h00, 6'h3F, 2'd1);
        pulse_hs();
        push_exp("blink_hour", 8'h01, 8'h00, 8'h00, 6'h0F, 2'd1);
        bus.btn_mode = 1'b1;
        bus.btn_inc  = 1'b1;
        bus.tick_s   = 1'b1;
        step(1);
        push_exp("mode_inc_tick_same", 8'h01, 8'h00, 8'h00, 6'h3F, 2'd2);
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        bus.tick_s   = 1'b0;
        step(1);

        // reach 12:34 in SET_MIN, then reset with buttons held
        press_mode();
        press_mode();
        press_inc(11);
        press_mode();
        press_inc(34);
        push_exp("set_1234", 8'h12, 8'h34, 8'h00, 6'h3F, 2'd2);
        rst          = 1'b1;
        bus.btn_mode = 1'b1;
        bus.btn_inc  = 1'b1;
        bus.tick_s   = 1'b1;
        step(1);
        push_exp("reset_mid_set", 8'h00, 8'h00, 8'h00, 6'h3F, 2'd0);
        rst        = 1'b0;
        bus.tick_s = 1'b0;
        step(5);
        push_exp("no_spurious_press", 8'h00, 8'h00, 8'h00, 6'h3F, 2'd0);
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        step(1);
        press_mode();
        push_exp("press_after_reset", 8'h00, 8'h00, 8'h00, 6'h3F, 2'd1);

        // ---------------- final report ----------------
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            @(negedge clk_in);
            #1;
        end
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
